// File: rtl/sc_fir_pkg.sv
// rtl/sc_fir_pkg.sv - shared constants and types for the SC FIR sequencer
package sc_fir_pkg;

  localparam int N      = 12;
  localparam int LENGTH = 19;
  localparam int IDX_W  = 5;
  localparam int EPOCH  = 1 << N;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // x^8+x^6+x^5+x^4+1 on a left-shifting register feeds back bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/sc_tap_selector.sv
// rtl/sc_tap_selector.sv - tap index generator for the SC FIR sequencer
// Round-robin by default; an 8-bit LFSR picks taps when SC_RAND_SEL_EN is defined.
module sc_tap_selector
  import sc_fir_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] tap_sel
);

`ifdef SC_RAND_SEL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // The LFSR free-runs across epochs; clear intentionally has no effect here
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign tap_sel = IDX_W'(lfsr_q % 8'(LENGTH));
`else
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = (cnt_q == IDX_W'(LENGTH - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tap_sel = cnt_q;
`endif

endmodule

// File: rtl/sc_fir_sequencer.sv
// rtl/sc_fir_sequencer.sv - runs one stochastic FIR epoch per accepted sample
// Tap order comes from sc_tap_selector (LFSR order when SC_RAND_SEL_EN is defined).
module sc_fir_sequencer
  import sc_fir_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N:0]       in_data,
  output logic             in_ready,
  output logic             sc_run,
  output logic [IDX_W-1:0] tap_sel,
  output logic [N:0]       tap_data,
  input  logic             sc_bit,
  output logic             out_valid,
  output logic [N:0]       out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [N:0] ACC_MAX = (N + 1)'(EPOCH);

  state_t       state_q, state_d;
  logic [N-1:0] epoch_q, epoch_d;
  logic [N:0]   acc_q;
  logic         run_q;
  logic         accept;
  logic [N:0]   dly_q [LENGTH];

  always_comb begin
    state_d   = state_q;
    epoch_d   = epoch_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    sc_run    = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          epoch_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sc_run  = 1'b1;
        epoch_d = epoch_q + 1'b1;
        if (&epoch_q) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // run_q lines up with sc_bit, which returns one cycle after its sc_run cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      epoch_q <= '0;
      acc_q   <= '0;
      run_q   <= 1'b0;
      for (int k = 0; k < LENGTH; k++) dly_q[k] <= '0;
    end else begin
      state_q <= state_d;
      epoch_q <= epoch_d;
      run_q   <= sc_run;
      if (accept) begin
        acc_q    <= '0;
        dly_q[0] <= in_data;
        for (int k = 1; k < LENGTH; k++) dly_q[k] <= dly_q[k-1];
      end else if (run_q && sc_bit && acc_q != ACC_MAX) begin
        acc_q <= acc_q + 1'b1;
      end
    end
  end

  sc_tap_selector u_tap_sel (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .advance (sc_run),
    .tap_sel (tap_sel)
  );

  assign tap_data = dly_q[tap_sel];
  assign out_data = acc_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// tb/tb_sc_fir_sequencer.sv - randomized self-checking bench for sc_fir_sequencer
// Reference: sample history queue, per-epoch bit pattern and tap-order arithmetic.
module tb_sc_fir_sequencer;
  import sc_fir_pkg::*;

  logic             clock = 1'b0;
  logic             reset, in_valid, sc_bit, out_ready;
  logic [N:0]       in_data;
  logic             in_ready, sc_run, out_valid, busy;
  logic [IDX_W-1:0] tap_sel;
  logic [N:0]       tap_data, out_data;

  int total = 0;
  int bad   = 0;
  int hist[$];
  int lfsr_m = 1;
  bit bits [EPOCH];
  int exp_cnt, run_cnt, lat, tap_err, wrap_seen, res;

  sc_fir_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sc_run(sc_run), .tap_sel(tap_sel), .tap_data(tap_data),
    .sc_bit(sc_bit), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  function automatic int hist_at(int k);
    if (k < hist.size()) return hist[k];
    return 0;
  endfunction

  task automatic apply_reset(input int cycles);
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sc_bit = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
    hist.delete();
    lfsr_m = 1;
  endtask

  // Drives one accept plus its epoch; stops on the first cycle out_valid is seen
  task automatic do_epoch(input int sample, input int pattern, input bit noisy);
    int idx, prev_idx, prev_sel, esel;
    bit prev_run;
    exp_cnt = 0;
    for (int k = 0; k < EPOCH; k++) begin
      case (pattern)
        0:       bits[k] = 1'b1;
        1:       bits[k] = 1'b0;
        2:       bits[k] = (k % 2 == 0);
        default: bits[k] = 1'($urandom_range(0, 1));
      endcase
      exp_cnt += int'(bits[k]);
    end
    in_valid = 1'b1; in_data = (N + 1)'(sample); sc_bit = (pattern == 0);
    @(posedge clock); #1;
    hist.push_front(sample);
    in_valid = 1'b0;
    run_cnt = 0; tap_err = 0; wrap_seen = 0; lat = -1; res = -1;
    idx = 0; prev_idx = 0; prev_run = 1'b0; prev_sel = -1;
    for (int s = 0; s < EPOCH + 8 && lat < 0; s++) begin
      if (out_valid === 1'b1) begin
        lat = s + 1;
        res = int'(out_data);
      end else begin
        if (sc_run === 1'b1) begin
          run_cnt++;
`ifdef SC_RAND_SEL_EN
          esel   = lfsr_m % LENGTH;
          lfsr_m = ((lfsr_m << 1) | int'(^(lfsr_m & 'hB8))) & 'hFF;
`else
          esel   = idx % LENGTH;
`endif
          if (int'(tap_sel) !== esel || int'(tap_data) !== hist_at(esel)) tap_err++;
          if (prev_sel == LENGTH - 1 && int'(tap_sel) == 0) wrap_seen = 1;
          prev_sel = int'(tap_sel);
        end
        if (prev_run) sc_bit = (prev_idx < EPOCH) ? bits[prev_idx] : 1'b0;
        else if (pattern < 2) sc_bit = (pattern == 0);
        else sc_bit = 1'($urandom_range(0, 1));
        prev_run = (sc_run === 1'b1);
        prev_idx = idx;
        if (sc_run === 1'b1) idx++;
        if (noisy) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data  = (N + 1)'($urandom);
        end
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int want_sel;
    apply_reset(2);
`ifdef SC_RAND_SEL_EN
    want_sel = lfsr_m % LENGTH;
`else
    want_sel = 0;
`endif
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (sc_run !== 1'b0) begin bad++; $display("FAIL reset_sc_run got=%b want=0", sc_run); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (int'(tap_data) !== 0) begin bad++; $display("FAIL reset_tap_data got=%0d want=0", tap_data); end
    total++; if (int'(out_data) !== 0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    total++; if (int'(tap_sel) !== want_sel) begin bad++; $display("FAIL reset_tap_sel got=%0d want=%0d", tap_sel, want_sel); end
  endtask

  task automatic test_counting();
    for (int p = 0; p < 3; p++) begin
      do_epoch(3, p, 1'b0);
      total++; if (run_cnt !== EPOCH) begin bad++; $display("FAIL count_run_cycles p=%0d got=%0d want=%0d", p, run_cnt, EPOCH); end
      total++; if (lat !== EPOCH + 2) begin bad++; $display("FAIL count_latency p=%0d got=%0d want=%0d", p, lat, EPOCH + 2); end
      total++; if (res !== exp_cnt) begin bad++; $display("FAIL count_result p=%0d got=%0d want=%0d", p, res, exp_cnt); end
      total++; if (tap_err !== 0) begin bad++; $display("FAIL count_taps p=%0d got=%0d want=0 errors", p, tap_err); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL count_busy_done p=%0d got=%b want=1", p, busy); end
      release_result();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL count_release p=%0d got valid=%b ready=%b want 0/1", p, out_valid, in_ready); end
    end
  endtask

  task automatic test_round_robin();
    apply_reset(1);
    for (int v = 1; v <= 3; v++) begin
      do_epoch(v, 3, 1'b1);
      total++; if (tap_err !== 0) begin bad++; $display("FAIL rr_taps epoch=%0d got=%0d want=0 errors", v, tap_err); end
      total++; if (res !== exp_cnt) begin bad++; $display("FAIL rr_result epoch=%0d got=%0d want=%0d", v, res, exp_cnt); end
`ifndef SC_RAND_SEL_EN
      total++; if (wrap_seen !== 1) begin bad++; $display("FAIL rr_wrap epoch=%0d got=%0d want=1", v, wrap_seen); end
`endif
      release_result();
    end
  endtask

  task automatic test_hold_done();
    int held;
    do_epoch(5, 3, 1'b0);
    held = exp_cnt;
    total++; if (res !== held) begin bad++; $display("FAIL hold_first_result got=%0d want=%0d", res, held); end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = (N + 1)'(7); out_ready = 1'b0;
      @(posedge clock); #1;
      total++; if (out_valid !== 1'b1 || int'(out_data) !== held) begin bad++; $display("FAIL hold_output c=%0d got valid=%b data=%0d want 1/%0d", c, out_valid, out_data, held); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c=%0d got=%b want=0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hold_to_idle got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    do_epoch(7, 3, 1'b0);
    total++; if (tap_err !== 0) begin bad++; $display("FAIL hold_delay_line got=%0d want=0 errors", tap_err); end
    total++; if (res !== exp_cnt || lat !== EPOCH + 2) begin bad++; $display("FAIL hold_next_epoch got res=%0d lat=%0d want %0d/%0d", res, lat, exp_cnt, EPOCH + 2); end
    release_result();
  endtask

  task automatic test_reset_midrun();
    int stray;
    in_valid = 1'b1; in_data = (N + 1)'(9);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    hist.delete();
    lfsr_m = 1;
    total++; if (sc_run !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL midreset_outputs got run=%b valid=%b want 0/0", sc_run, out_valid); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midreset_idle got busy=%b ready=%b want 0/1", busy, in_ready); end
    total++; if (int'(tap_data) !== 0) begin bad++; $display("FAIL midreset_tap_data got=%0d want=0", tap_data); end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL midreset_no_result got=%0d want=0 valid cycles", stray); end
    do_epoch(0, 3, 1'b1);
    total++; if (tap_err !== 0) begin bad++; $display("FAIL midreset_taps_zero got=%0d want=0 errors", tap_err); end
    total++; if (res !== exp_cnt) begin bad++; $display("FAIL midreset_result got=%0d want=%0d", res, exp_cnt); end
    release_result();
  endtask

  task automatic test_back_to_back();
    for (int e = 0; e < 2; e++) begin
      do_epoch(int'($urandom_range(0, (1 << (N + 1)) - 1)), 3, 1'b1);
      total++; if (res !== exp_cnt) begin bad++; $display("FAIL b2b_result e=%0d got=%0d want=%0d", e, res, exp_cnt); end
      total++; if (tap_err !== 0 || lat !== EPOCH + 2) begin bad++; $display("FAIL b2b_taps_latency e=%0d got err=%0d lat=%0d want 0/%0d", e, tap_err, lat, EPOCH + 2); end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_round_robin();
    test_hold_done();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
